// File: rtl/rate_uart_reporter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | rate_uart_reporter                                                       |
// | Converts the 16-bit samples-per-second value to five ASCII digits plus   |
// | CR/LF and sends them over an 8N1 UART on change or on heartbeat expiry.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rate_uart_reporter #(
  parameter int unsigned BAUD_DIV         = 434,
  parameter int unsigned HEARTBEAT_CYCLES = 50000000
) (
  input  logic        iClk50M,
  input  logic        iRst_n,
  input  logic [15:0] iRate,
  input  logic        iEnable,
  output logic        oTxd,
  output logic        oBusy
);

  localparam int unsigned c_HB_BITS = $clog2(HEARTBEAT_CYCLES + 1);
  localparam int unsigned c_HB_W    = (c_HB_BITS > 26) ? c_HB_BITS : 26;
  localparam int unsigned c_TMR_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [c_HB_W-1:0]  c_HB_MAX     = c_HB_W'(HEARTBEAT_CYCLES);
  localparam logic [c_TMR_W-1:0] c_TMR_RELOAD = c_TMR_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SEND    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [15:0]         r_lastSent;
  logic [c_HB_W-1:0]   r_hbCnt;
  logic [15:0]         r_bin;
  logic [19:0]         r_bcd;
  logic [3:0]          r_cnvCnt;
  logic [2:0]          r_char;
  logic [3:0]          r_bit;
  logic [c_TMR_W-1:0]  r_tmr;
  logic                r_done;
  logic                r_txd;

  logic                w_hbFull;
  logic                w_trigger;
  logic                w_sendTick;
  logic [19:0]         w_bcdAdj;
  logic [7:0]          w_byte;
  logic                w_txBit;

  always_ff @(posedge iClk50M or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_hbFull    = 1'b0;
    if (HEARTBEAT_CYCLES != 0) begin
      w_hbFull = (r_hbCnt == c_HB_MAX);
    end
    w_trigger  = iEnable && ((iRate != r_lastSent) || w_hbFull);
    w_sendTick = (r_tmr == '0);
    case (r_state)
      IDLE:    if (w_trigger) w_stateNext = CONVERT;
      CONVERT: if (r_cnvCnt == 4'd15) w_stateNext = SEND;
      SEND:    if (w_sendTick && r_done) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Double-dabble correction: any digit >= 5 would overflow past 9 once doubled.
  always_comb begin
    w_bcdAdj = r_bcd;
    for (int d = 0; d < 5; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_bcdAdj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    case (r_char)
      3'd0:    w_byte = {4'h3, r_bcd[19:16]};
      3'd1:    w_byte = {4'h3, r_bcd[15:12]};
      3'd2:    w_byte = {4'h3, r_bcd[11:8]};
      3'd3:    w_byte = {4'h3, r_bcd[7:4]};
      3'd4:    w_byte = {4'h3, r_bcd[3:0]};
      3'd5:    w_byte = 8'h0D;
      default: w_byte = 8'h0A;
    endcase
    if (r_bit == 4'd0) begin
      w_txBit = 1'b0;
    end else if (r_bit >= 4'd9) begin
      w_txBit = 1'b1;
    end else begin
      w_txBit = w_byte[3'(r_bit - 4'd1)];
    end
  end

  always_ff @(posedge iClk50M or negedge iRst_n) begin
    if (!iRst_n) begin
      r_lastSent <= '0;
      r_hbCnt    <= '0;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnvCnt   <= '0;
      r_char     <= '0;
      r_bit      <= '0;
      r_tmr      <= '0;
      r_done     <= 1'b0;
      r_txd      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_txd <= 1'b1;
          if (w_trigger) begin
            r_bin      <= iRate;
            r_lastSent <= iRate;
            r_bcd      <= '0;
            r_hbCnt    <= '0;
            r_cnvCnt   <= '0;
            r_char     <= '0;
            r_bit      <= '0;
            r_tmr      <= '0;
            r_done     <= 1'b0;
          end else if (r_hbCnt != c_HB_MAX) begin
            r_hbCnt <= r_hbCnt + c_HB_W'(1);
          end
        end
        CONVERT: begin
          r_bcd    <= {w_bcdAdj[18:0], r_bin[15]};
          r_bin    <= {r_bin[14:0], 1'b0};
          r_cnvCnt <= r_cnvCnt + 4'd1;
        end
        SEND: begin
          // Timer at zero marks a bit boundary; r_done means the final stop bit is on the line.
          if (w_sendTick) begin
            if (!r_done) begin
              r_txd <= w_txBit;
              r_tmr <= c_TMR_RELOAD;
              if (r_bit == 4'd9) begin
                r_bit <= '0;
                if (r_char == 3'd6) begin
                  r_done <= 1'b1;
                end else begin
                  r_char <= r_char + 3'd1;
                end
              end else begin
                r_bit <= r_bit + 4'd1;
              end
            end else begin
              r_txd <= 1'b1;
            end
          end else begin
            r_tmr <= r_tmr - c_TMR_W'(1);
          end
        end
        default: r_txd <= 1'b1;
      endcase
    end
  end

  assign oTxd  = r_txd;
  assign oBusy = (r_state != IDLE);

endmodule
`default_nettype wire
